// File: rtl/fmdll_pkg.sv
// fmdll_pkg: shared encodings for the FMDLL control-code loop.
package fmdll_pkg;
  typedef enum logic [1:0] {
    SEL_HOLD = 2'b00,
    SEL_UP   = 2'b01,
    SEL_DN   = 2'b10,
    SEL_INV  = 2'b11
  } sel_e;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_COARSE = 2'b01,
    ST_FINE   = 2'b10,
    ST_LOCK   = 2'b11
  } state_e;
  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DN   = 2'b10
  } dir_e;
endpackage

// File: rtl/fmdll_sat_addsub.sv
// fmdll_sat_addsub: code +/- step computed one bit wider, clamped to [0, 2^CODE_W-1].
module fmdll_sat_addsub #(
  parameter int CODE_W = 6
) (
  input  logic [CODE_W-1:0] i_code,
  input  logic [CODE_W-1:0] i_step,
  input  logic              i_up,
  output logic [CODE_W-1:0] o_code,
  output logic              o_sat
);
  logic [CODE_W:0] w_sum;
  // Both operands are below 2^CODE_W, so the extra bit flags overflow and underflow alike.
  assign w_sum  = i_up ? {1'b0, i_code} + {1'b0, i_step} : {1'b0, i_code} - {1'b0, i_step};
  assign o_sat  = w_sum[CODE_W];
  assign o_code = o_sat ? (i_up ? '1 : '0) : w_sum[CODE_W-1:0];
endmodule

// File: rtl/fmdll_code_ctrl.sv
// fmdll_code_ctrl: integrates per-window Sel verdicts into a saturating delay-line code,
// with coarse binary-search acquisition, fine +/-1 tracking and dither-based lock.
module fmdll_code_ctrl
  import fmdll_pkg::*;
#(
  parameter int CODE_W    = 6,
  parameter int CODE_RST  = 32,
  parameter int STEP_INIT = 8,
  parameter int LOCK_CNT  = 4
) (
  input  logic              clk_ext,
  input  logic              rst_n,
  input  logic              en,
  input  logic              DIV_M,
  input  logic [1:0]        Sel,
  output logic [CODE_W-1:0] ctrl_code,
  output logic              lock,
  output logic [1:0]        state,
  output logic              sat
);
  localparam int CNT_W = $clog2(LOCK_CNT + 1);
  localparam logic [CODE_W-1:0] C_RST  = CODE_W'(CODE_RST);
  localparam logic [CODE_W-1:0] C_STEP = CODE_W'(STEP_INIT);
  localparam logic [CNT_W-1:0]  C_LOCK = CNT_W'(LOCK_CNT);

  state_e            r_state, w_state_nx;
  dir_e              r_dir, w_dir_nx, w_dir_sel;
  logic [CODE_W-1:0] r_code, w_code_nx, r_step, w_step_nx, w_step_eff, w_sum;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
  logic              r_lock, w_lock_nx, r_sat, w_sat_nx, r_div_m_q;
  logic              w_win, w_mv, w_up, w_rev, w_same, w_add_sat;

  assign w_win      = DIV_M & ~r_div_m_q;
  assign w_up       = Sel == SEL_UP;
  assign w_mv       = w_win & (w_up | (Sel == SEL_DN));
  assign w_dir_sel  = w_up ? DIR_UP : DIR_DN;
  assign w_rev      = (r_dir != DIR_NONE) && (w_dir_sel != r_dir);
  assign w_same     = w_mv & (w_dir_sel == r_dir);
  assign w_step_eff = (r_state == ST_COARSE && w_rev) ? r_step >> 1 : r_step;

  fmdll_sat_addsub #(.CODE_W(CODE_W)) u_addsub (
    .i_code (r_code),
    .i_step (w_step_eff),
    .i_up   (w_up),
    .o_code (w_sum),
    .o_sat  (w_add_sat)
  );

  always_comb begin
    w_state_nx = r_state;
    w_dir_nx   = r_dir;
    w_code_nx  = r_code;
    w_step_nx  = r_step;
    w_cnt_nx   = r_cnt;
    w_lock_nx  = r_lock;
    w_sat_nx   = r_sat;
    if (!en) begin
      w_state_nx = ST_IDLE;
      w_dir_nx   = DIR_NONE;
      w_code_nx  = C_RST;
      w_step_nx  = C_STEP;
      w_cnt_nx   = '0;
      w_lock_nx  = 1'b0;
      w_sat_nx   = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nx = ST_COARSE;
        ST_COARSE: if (w_mv) begin
          w_code_nx = w_sum;
          w_sat_nx  = w_add_sat;
          w_step_nx = w_step_eff;
          w_dir_nx  = w_dir_sel;
          if (w_step_eff == CODE_W'(1)) begin
            w_state_nx = ST_FINE;
            w_cnt_nx   = '0;
          end
        end
        default: if (w_win) begin
          if (w_mv) begin
            w_code_nx = w_sum;
            w_sat_nx  = w_add_sat;
            w_dir_nx  = w_dir_sel;
          end
          // Reversals and holds count toward lock; the counter parks at LOCK_CNT while locked.
          w_cnt_nx = w_same ? '0 : (r_cnt == C_LOCK ? r_cnt : r_cnt + 1'b1);
          if (r_state == ST_LOCK && w_same) begin
            w_state_nx = ST_FINE;
            w_lock_nx  = 1'b0;
          end else if (r_state == ST_FINE && w_cnt_nx == C_LOCK) begin
            w_state_nx = ST_LOCK;
            w_lock_nx  = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_dir     <= DIR_NONE;
      r_code    <= C_RST;
      r_step    <= C_STEP;
      r_cnt     <= '0;
      r_lock    <= 1'b0;
      r_sat     <= 1'b0;
      r_div_m_q <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_dir     <= w_dir_nx;
      r_code    <= w_code_nx;
      r_step    <= w_step_nx;
      r_cnt     <= w_cnt_nx;
      r_lock    <= w_lock_nx;
      r_sat     <= w_sat_nx;
      r_div_m_q <= DIV_M;
    end
  end

  assign ctrl_code = r_code;
  assign lock      = r_lock;
  assign state     = r_state;
  assign sat       = r_sat;
endmodule

// File: tb/tb_fmdll_code_ctrl.sv
// tb_fmdll_code_ctrl: directed scenarios plus random windows checked against an integer model.
module tb_fmdll_code_ctrl;
  logic       clk_ext = 0;
  logic       rst_n, en, DIV_M;
  logic [1:0] Sel;
  logic [5:0] ctrl_code;
  logic       lock, sat;
  logic [1:0] state;

  int n_run = 0, n_fail = 0;
  int m_code, m_step, m_st, m_dir, m_cnt, m_lock, m_sat;

  fmdll_code_ctrl dut (
    .clk_ext(clk_ext), .rst_n(rst_n), .en(en), .DIV_M(DIV_M), .Sel(Sel),
    .ctrl_code(ctrl_code), .lock(lock), .state(state), .sat(sat)
  );

  always #5 clk_ext = ~clk_ext;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".code"}, 32'(ctrl_code), m_code);
    chk({tag, ".lock"}, 32'(lock), m_lock);
    chk({tag, ".state"}, 32'(state), m_st);
    chk({tag, ".sat"}, 32'(sat), m_sat);
  endtask

  function automatic void model_reset();
    m_code = 32; m_step = 8; m_st = 0; m_dir = 0; m_cnt = 0; m_lock = 0; m_sat = 0;
  endfunction

  function automatic void apply(input int raw);
    m_sat  = (raw < 0 || raw > 63) ? 1 : 0;
    m_code = raw < 0 ? 0 : (raw > 63 ? 63 : raw);
  endfunction

  // Direction as +1/-1/0; a reversal halves the coarse step, holds and reversals count toward lock.
  function automatic void model_win(input int s);
    int mv = s == 1 ? 1 : (s == 2 ? -1 : 0);
    bit rev = m_dir != 0 && mv != 0 && mv != m_dir;
    bit same = mv != 0 && mv == m_dir;
    if (m_st == 1) begin
      if (mv != 0) begin
        if (rev) m_step = m_step / 2;
        apply(m_code + mv * m_step);
        m_dir = mv;
        if (m_step == 1) begin m_st = 2; m_cnt = 0; end
      end
    end else if (m_st >= 2) begin
      if (mv != 0) begin apply(m_code + mv); m_dir = mv; end
      if (same) begin
        m_cnt = 0;
        if (m_st == 3) begin m_st = 2; m_lock = 0; end
      end else begin
        if (m_cnt < 4) m_cnt++;
        if (m_st == 2 && m_cnt == 4) begin m_st = 3; m_lock = 1; end
      end
    end
  endfunction

  task automatic win(input logic [1:0] s, input string tag);
    @(negedge clk_ext); DIV_M = 1; Sel = s;
    @(posedge clk_ext); model_win(int'(s));
    #1 check_all(tag);
    @(negedge clk_ext); DIV_M = 0; Sel = 2'($urandom);
  endtask

  task automatic restart(input string tag);
    @(negedge clk_ext); en = 0;
    @(negedge clk_ext); model_reset(); check_all({tag, ".off"});
    en = 1;
    @(negedge clk_ext); m_st = 1; check_all({tag, ".on"});
  endtask

  initial begin
    int c2[5] = '{40, 48, 44, 46, 45};
    logic [1:0] s2[5] = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b10};
    int c3[4] = '{46, 45, 46, 45};
    logic [1:0] s3[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    rst_n = 0; en = 0; DIV_M = 0; Sel = 0;
    model_reset();
    #12 check_all("reset");
    @(negedge clk_ext); rst_n = 1;
    @(negedge clk_ext); en = 1;
    @(negedge clk_ext); m_st = 1;
    repeat (10) begin @(negedge clk_ext); Sel = 2'($urandom); check_all("s1_idle_en"); end
    for (int i = 0; i < 5; i++) begin win(s2[i], "s2"); chk("s2_code", 32'(ctrl_code), c2[i]); end
    chk("s2_fine", 32'(state), 2);
    for (int i = 0; i < 4; i++) begin
      win(s3[i], "s3"); chk("s3_code", 32'(ctrl_code), c3[i]);
      chk("s3_lock", 32'(lock), i == 3 ? 1 : 0);
    end
    chk("s3_state", 32'(state), 3);
    win(2'b01, "s4a"); chk("s4a_lock", 32'(lock), 1); chk("s4a_code", 32'(ctrl_code), 46);
    win(2'b01, "s4b"); chk("s4b_lock", 32'(lock), 0); chk("s4b_state", 32'(state), 2);
    chk("s4b_code", 32'(ctrl_code), 47);
    win(2'b11, "s4c"); win(2'b11, "s4d"); chk("s4_inv_code", 32'(ctrl_code), 47);
    win(2'b10, "s4e"); win(2'b01, "s4f"); chk("s4_inv_counted", 32'(lock), 1);
    repeat (15) win(2'b01, "s5_climb");
    chk("s5_at62", 32'(ctrl_code), 62); chk("s5_fine", 32'(state), 2);
    win(2'b01, "s5a"); chk("s5a_code", 32'(ctrl_code), 63); chk("s5a_sat", 32'(sat), 0);
    win(2'b01, "s5b"); chk("s5b_code", 32'(ctrl_code), 63); chk("s5b_sat", 32'(sat), 1);
    win(2'b00, "s5hold"); chk("s5hold_sat", 32'(sat), 1);
    win(2'b10, "s5c"); chk("s5c_code", 32'(ctrl_code), 62); chk("s5c_sat", 32'(sat), 0);
    restart("s5r");
    repeat (4) win(2'b01, "s5_coarse_up");
    chk("s5_coarse_top", 32'(ctrl_code), 63); chk("s5_coarse_sat", 32'(sat), 1);
    restart("s5r2");
    repeat (5) win(2'b10, "s5_coarse_dn");
    chk("s5_coarse_bot", 32'(ctrl_code), 0); chk("s5_coarse_bsat", 32'(sat), 1);
    restart("s6r");
    @(negedge clk_ext); DIV_M = 1; Sel = 2'b01;
    @(posedge clk_ext); model_win(1);
    repeat (20) begin @(negedge clk_ext); Sel = 2'($urandom); end
    check_all("s6_held");
    chk("s6_held_code", 32'(ctrl_code), 40);
    DIV_M = 0;
    @(negedge clk_ext); check_all("s6_held_after");
    @(negedge clk_ext); en = 0; DIV_M = 1; Sel = 2'b01;
    @(negedge clk_ext); model_reset(); check_all("s6_en_win");
    chk("s6_en_code", 32'(ctrl_code), 32); chk("s6_en_state", 32'(state), 0);
    DIV_M = 0; en = 1;
    @(negedge clk_ext); m_st = 1; check_all("s6_reen");
    win(2'b01, "s6_pre_rst");
    @(negedge clk_ext); #2 rst_n = 0;
    #1 model_reset(); check_all("s6_async_rst");
    @(negedge clk_ext); rst_n = 1;
    @(negedge clk_ext); m_st = 1; check_all("s6_after_rst");
    repeat (400) begin
      if ($urandom_range(0, 24) == 0) restart("rnd_restart");
      else win(2'($urandom), "rnd");
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
